// File: rtl/vga_pkg.sv
// Shared definitions for the VGA rectangle scheduler: frame geometry,
// the rectangle descriptor layout and the commit FSM state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  // Coordinate widths baked into the descriptor layout.
  localparam int RECT_XW = 10;
  localparam int RECT_YW = 10;

  typedef struct packed {
    logic [RECT_XW-1:0] x0;
    logic [RECT_XW-1:0] x1;
    logic [RECT_YW-1:0] y0;
    logic [RECT_YW-1:0] y1;
    logic [2:0]         rgb;
    logic               en;
  } rect_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

endpackage

// File: rtl/vga_rect_hit.sv
// Combinational coverage test of one rectangle against the current pixel.
// Inverted bounds (x0>x1 or y0>y1) can never satisfy both compares.
module vga_rect_hit
  import vga_pkg::*;
(
  input  rect_t              i_rect,
  input  logic [RECT_XW-1:0] i_pix_x,
  input  logic [RECT_YW-1:0] i_pix_y,
  output logic               o_hit
);

  logic w_in_x;
  logic w_in_y;

  assign w_in_x = (i_pix_x >= i_rect.x0) && (i_pix_x <= i_rect.x1);
  assign w_in_y = (i_pix_y >= i_rect.y0) && (i_pix_y <= i_rect.y1);
  assign o_hit  = i_rect.en && w_in_x && w_in_y;

endmodule

// File: rtl/vga_rect_scheduler.sv
// Double-banked rectangle overlay: descriptors are staged in a shadow bank and
// copied to the active bank at vblank; a 2-stage pixel pipeline picks a colour.
module vga_rect_scheduler
  import vga_pkg::*;
#(
  parameter int          NRECT  = 4,
  parameter int          XW     = 10,
  parameter int          YW     = 10,
  parameter logic [2:0]  BG_RGB = 3'b000,
  localparam int         IW     = (NRECT > 1) ? $clog2(NRECT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [XW-1:0] pix_x,
  input  logic [YW-1:0] pix_y,
  input  logic          pix_active,
  input  logic          vblank_start,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_idx,
  input  logic [XW-1:0] cfg_x0,
  input  logic [XW-1:0] cfg_x1,
  input  logic [YW-1:0] cfg_y0,
  input  logic [YW-1:0] cfg_y1,
  input  logic [2:0]    cfg_rgb,
  input  logic          cfg_en,
  input  logic          commit,
  output logic          commit_pending,
  output logic          commit_done,
  output logic          vga_red,
  output logic          vga_green,
  output logic          vga_blue,
  output logic          hit,
  output logic [IW-1:0] hit_idx
);

  state_t          r_state;
  state_t          w_next_state;
  logic            w_cfg_wr;

  rect_t           r_shadow [NRECT];
  rect_t           r_active [NRECT];
  rect_t           w_cfg_rect;

  logic [NRECT-1:0] w_hit_vec;
  logic [NRECT-1:0] r_hit_vec;
  logic             r_act_d;
  logic             w_win_found;
  logic [IW-1:0]    w_win_idx;
  logic [2:0]       w_rgb;
  logic [2:0]       r_rgb;
  logic             r_hit;
  logic [IW-1:0]    r_hit_idx;

  assign w_cfg_rect = '{x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1,
                        rgb: cfg_rgb, en: cfg_en};

  // Commit FSM
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    cfg_ready      = 1'b0;
    commit_pending = 1'b0;
    commit_done    = 1'b0;
    w_cfg_wr       = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        w_cfg_wr  = cfg_valid;
        if (commit) w_next_state = PENDING;
      end
      PENDING: begin
        commit_pending = 1'b1;
        if (vblank_start) w_next_state = APPLY;
      end
      APPLY: begin
        commit_done  = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Descriptor banks. A write in the commit clk lands in shadow before APPLY copies it.
  // NOTE: these small banks are reset explicitly because an all-zero descriptor is the defined "disabled" state; larger RAMs normally are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NRECT; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_cfg_wr) r_shadow[cfg_idx] <= w_cfg_rect;
      if (r_state == APPLY) r_active <= r_shadow;
    end
  end

  for (genvar g = 0; g < NRECT; g++) begin : g_hit
    vga_rect_hit u_hit (
      .i_rect  (r_active[g]),
      .i_pix_x (pix_x),
      .i_pix_y (pix_y),
      .o_hit   (w_hit_vec[g])
    );
  end

  // Lowest index wins: scan downwards so the last assignment is the smallest hit.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (r_hit_vec[i]) begin
        w_win_found = 1'b1;
        w_win_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_rgb = 3'b000;
    if (w_win_found)  w_rgb = r_active[w_win_idx].rgb;
    else if (r_act_d) w_rgb = BG_RGB;
  end

  // Two pipeline stages, both advancing only on pixel strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_vec <= '0;
      r_act_d   <= 1'b0;
      r_rgb     <= 3'b000;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else if (pix_en) begin
      r_hit_vec <= w_hit_vec & {NRECT{pix_active}};
      r_act_d   <= pix_active;
      r_rgb     <= w_rgb;
      r_hit     <= w_win_found;
      r_hit_idx <= w_win_idx;
    end
  end

  assign vga_red   = r_rgb[2];
  assign vga_green = r_rgb[1];
  assign vga_blue  = r_rgb[0];
  assign hit       = r_hit;
  assign hit_idx   = r_hit_idx;

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Directed bench for vga_rect_scheduler: pixels, vblank and commits are driven
// as individual steps and outputs are compared against hand-computed values.
module tb_vga_rect_scheduler;

  localparam int         NRECT = 4;
  localparam int         XW    = 10;
  localparam int         YW    = 10;
  localparam int         IW    = 2;
  localparam logic [2:0] BG    = 3'b011;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en, pix_active, vblank_start;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          cfg_valid, cfg_ready, cfg_en, commit;
  logic [IW-1:0] cfg_idx;
  logic [XW-1:0] cfg_x0, cfg_x1;
  logic [YW-1:0] cfg_y0, cfg_y1;
  logic [2:0]    cfg_rgb;
  logic          commit_pending, commit_done;
  logic          vga_red, vga_green, vga_blue, hit;
  logic [IW-1:0] hit_idx;

  int n_checks = 0;
  int n_pass   = 0;

  vga_rect_scheduler #(.NRECT(NRECT), .XW(XW), .YW(YW), .BG_RGB(BG)) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_en         (pix_en),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_active     (pix_active),
    .vblank_start   (vblank_start),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_idx        (cfg_idx),
    .cfg_x0         (cfg_x0),
    .cfg_x1         (cfg_x1),
    .cfg_y0         (cfg_y0),
    .cfg_y1         (cfg_y1),
    .cfg_rgb        (cfg_rgb),
    .cfg_en         (cfg_en),
    .commit         (commit),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .vga_red        (vga_red),
    .vga_green      (vga_green),
    .vga_blue       (vga_blue),
    .hit            (hit),
    .hit_idx        (hit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {hit, hit_idx, r, g, b}
  function automatic logic [5:0] pix_out();
    return {hit, hit_idx, vga_red, vga_green, vga_blue};
  endfunction

  // One pixel period: strobe clk then idle clk. Returns at the negedge after the strobe edge.
  task automatic step(input int x, input int y, input bit vb, input bit cm);
    @(negedge clk);
    pix_x        = XW'(x);
    pix_y        = YW'(y);
    pix_active   = (x < 640) && (y < 480);
    pix_en       = 1'b1;
    vblank_start = vb;
    commit       = cm;
    @(negedge clk);
    pix_en       = 1'b0;
    vblank_start = 1'b0;
    commit       = 1'b0;
  endtask

  // Present a pixel, push it to the output with an inactive filler pixel, compare.
  task automatic probe(input string tag, input int x, input int y,
                       input bit e_hit, input logic [IW-1:0] e_idx, input logic [2:0] e_rgb);
    step(x, y, 1'b0, 1'b0);
    step(700, 500, 1'b0, 1'b0);
    check(tag, 32'(pix_out()), 32'({e_hit, e_idx, e_rgb}));
  endtask

  task automatic wr(input int idx, input int x0, input int x1, input int y0, input int y1,
                    input logic [2:0] rgb, input bit en);
    bit done = 1'b0;
    @(negedge clk);
    cfg_idx = IW'(idx); cfg_x0 = XW'(x0); cfg_x1 = XW'(x1);
    cfg_y0 = YW'(y0); cfg_y1 = YW'(y1); cfg_rgb = rgb; cfg_en = en;
    cfg_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (cfg_ready) done = 1'b1;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (!done) check("wr_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 0; pix_active = 0; vblank_start = 0; pix_x = '0; pix_y = '0;
    cfg_valid = 0; cfg_idx = '0; cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0;
    cfg_rgb = '0; cfg_en = 0; commit = 0;
    repeat (2) @(negedge clk);
    check("rst_out",     32'(pix_out()), 32'd0);
    check("rst_ready",   32'(cfg_ready), 32'd1);
    check("rst_pending", 32'(commit_pending), 32'd0);
    check("rst_done",    32'(commit_done), 32'd0);
    rst = 1'b0;

    // Empty banks: background on visible pixels, black off-screen
    probe("bg_0_0",     0,   0,   1'b0, 2'd0, BG);
    probe("bg_639_479", 639, 479, 1'b0, 2'd0, BG);
    probe("blank_700",  700, 10,  1'b0, 2'd0, 3'b000);

    // Slot 0 red, committed mid-frame at row 100
    wr(0, 150, 299, 40, 159, 3'b100, 1'b1);
    step(200, 100, 1'b0, 1'b0);
    do_commit();
    check("pend_after_commit", 32'({commit_pending, cfg_ready, commit_done}), 32'b100);
    probe("still_bg_row100", 200, 100, 1'b0, 2'd0, BG);
    step(0, 480, 1'b1, 1'b0);
    check("apply_state", 32'({commit_pending, cfg_ready, commit_done}), 32'b001);
    @(negedge clk);
    check("idle_again", 32'({commit_pending, cfg_ready, commit_done}), 32'b010);

    probe("red_tl",   150, 40,  1'b1, 2'd0, 3'b100);
    probe("red_br",   299, 159, 1'b1, 2'd0, 3'b100);
    probe("red_mid",  200, 100, 1'b1, 2'd0, 3'b100);
    probe("left_out", 149, 40,  1'b0, 2'd0, BG);
    probe("right_out",300, 40,  1'b0, 2'd0, BG);
    probe("top_out",  150, 39,  1'b0, 2'd0, BG);
    probe("bot_out",  150, 160, 1'b0, 2'd0, BG);

    // Latency: exactly two strobes, and holds while pix_en is low
    step(150, 40, 1'b0, 1'b0);
    check("lat_1strobe", 32'({vga_red, hit}), 32'b00);
    @(negedge clk); pix_x = 10'd700; pix_active = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_no_en", 32'({vga_red, hit}), 32'b00);
    step(640, 40, 1'b0, 1'b0);
    check("lat_2strobe", 32'({vga_red, hit}), 32'b11);
    step(700, 40, 1'b0, 1'b0);
    check("red_off_640", 32'({vga_red, hit}), 32'b00);

    // Overlap, inverted rectangle; shadow writes stay invisible until commit
    wr(0, 100, 200, 200, 300, 3'b010, 1'b1);
    wr(1, 150, 250, 200, 300, 3'b001, 1'b1);
    wr(2, 300, 200, 0,   479, 3'b111, 1'b1);
    probe("old_bank", 150, 40, 1'b1, 2'd0, 3'b100);
    do_commit();
    step(0, 480, 1'b1, 1'b0);
    check("done_ovl", 32'(commit_done), 32'd1);
    probe("grn_150", 150, 250, 1'b1, 2'd0, 3'b010);
    probe("grn_200", 200, 250, 1'b1, 2'd0, 3'b010);
    probe("blu_201", 201, 250, 1'b1, 2'd1, 3'b001);
    probe("blu_250", 250, 300, 1'b1, 2'd1, 3'b001);
    probe("bg_251",  251, 250, 1'b0, 2'd0, BG);
    probe("bg_row301", 250, 301, 1'b0, 2'd0, BG);
    probe("inverted", 260, 250, 1'b0, 2'd0, BG);

    // cfg stalled while PENDING, accepted in first IDLE clk (after APPLY)
    do_commit();
    @(negedge clk);
    cfg_idx = 2'd3; cfg_x0 = 10'd0; cfg_x1 = 10'd639; cfg_y0 = 10'd0; cfg_y1 = 10'd479;
    cfg_rgb = 3'b111; cfg_en = 1'b1; cfg_valid = 1'b1;
    check("stall_ready", 32'(cfg_ready), 32'd0);
    commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    @(negedge clk);
    check("stall_pend", 32'({commit_pending, cfg_ready}), 32'b10);
    step(0, 480, 1'b1, 1'b0);
    check("stall_apply", 32'({cfg_ready, commit_done}), 32'b01);
    @(negedge clk);
    check("stall_accept", 32'({cfg_ready, commit_done}), 32'b10);
    @(negedge clk); cfg_valid = 1'b0;
    probe("slot3_not_active", 500, 400, 1'b0, 2'd0, BG);
    do_commit();
    step(0, 480, 1'b1, 1'b0);
    probe("slot3_white", 500, 400, 1'b1, 2'd3, 3'b111);
    probe("prio_0_over_3", 150, 250, 1'b1, 2'd0, 3'b010);

    // Write and commit in the same IDLE clk: write is included
    @(negedge clk);
    cfg_idx = 2'd3; cfg_rgb = 3'b101; cfg_valid = 1'b1; commit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; commit = 1'b0;
    check("wc_pend", 32'(commit_pending), 32'd1);
    step(0, 480, 1'b1, 1'b0);
    probe("wc_applied", 500, 400, 1'b1, 2'd3, 3'b101);

    // Commit together with vblank_start: waits for the next vblank
    wr(3, 0, 639, 0, 479, 3'b101, 1'b0);
    step(0, 480, 1'b1, 1'b1);
    check("cv_pend", 32'({commit_pending, commit_done}), 32'b10);
    probe("cv_not_yet", 500, 400, 1'b1, 2'd3, 3'b101);
    step(0, 480, 1'b1, 1'b0);
    check("cv_done", 32'(commit_done), 32'd1);
    probe("cv_applied", 500, 400, 1'b0, 2'd0, BG);

    // Reset while PENDING clears everything, no commit_done follows
    wr(0, 0, 639, 0, 479, 3'b100, 1'b1);
    do_commit();
    check("rp_pend", 32'(commit_pending), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rp_async", 32'({commit_pending, cfg_ready, pix_out()}), 32'({2'b01, 6'd0}));
    @(negedge clk); rst = 1'b0;
    step(0, 480, 1'b1, 1'b0);
    check("rp_no_done", 32'(commit_done), 32'd0);
    probe("rp_bg_a", 150, 250, 1'b0, 2'd0, BG);
    do_commit();
    step(0, 480, 1'b1, 1'b0);
    check("rp_done_clean", 32'(commit_done), 32'd1);
    probe("rp_bg_b", 500, 400, 1'b0, 2'd0, BG);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
